// File: rtl/fetch_buffer_pkg.sv
// ============================================================================
// Module   : fetch_buffer_pkg
// Brief    : Shared types and constants for the instruction fetch buffer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_buffer_pkg;

    localparam logic [31:0] c_nop_instr = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_type;

    typedef struct packed {
        logic        imem_ready;
        logic        imem_rvalid;
        logic [31:0] imem_rdata;
        logic        flush;
        logic [31:0] flush_pc;
        logic        out_ready;
    } fetch_buffer_in_type;

    typedef struct packed {
        logic        imem_valid;
        logic [31:0] imem_addr;
        logic        out_valid;
        logic [31:0] out_instr;
        logic [31:0] out_pc;
    } fetch_buffer_out_type;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_buffer_if.sv
// ============================================================================
// Module   : fetch_buffer_if
// Brief    : Memory request/response, redirect and decode handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_buffer_if;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush;
    logic [31:0] flush_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_ready;

    modport master (
        output imem_valid, imem_addr, out_valid, out_instr, out_pc,
        input  imem_ready, imem_rvalid, imem_rdata, flush, flush_pc, out_ready
    );

    modport slave (
        input  imem_valid, imem_addr, out_valid, out_instr, out_pc,
        output imem_ready, imem_rvalid, imem_rdata, flush, flush_pc, out_ready
    );
endinterface

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module   : fetch_fifo
// Brief    : Parameterised synchronous FIFO with clear, occupancy and head.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned c_ptr_w = $clog2(DEPTH);
    localparam int unsigned c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_cnt_w-1:0] r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_do_pop  = i_pop  & ~i_clear & (r_count != '0);
    assign w_do_push = i_push & ~i_clear & (r_count != c_full);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : Sequential instruction fetch with credit-limited requests, an
//            in-order response queue and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter logic [31:0] START_ADDR = 32'h0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_buffer_if.master bus
);

    localparam int unsigned c_cnt_w = $clog2(DEPTH) + 1;
    localparam int unsigned c_sum_w = c_cnt_w + 1;
    localparam logic [c_sum_w-1:0] c_depth = c_sum_w'(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("fetch_buffer: DEPTH must be a power of two in 2..16");
    end

    fetch_buffer_in_type  w_in;
    fetch_buffer_out_type w_out;
    fetch_entry_type      w_push_entry;
    fetch_entry_type      w_head_entry;

    logic [31:0]        r_pc;
    logic [31:0]        w_pcq_head;
    logic [c_cnt_w-1:0] w_count;
    logic [c_cnt_w-1:0] w_outstanding;
    logic [c_cnt_w-1:0] r_discard;
    logic [c_sum_w-1:0] w_inflight;
    logic               w_req;
    logic               w_accept;
    logic               w_keep;
    logic               w_out_valid;
    logic               w_pop;

    always_comb begin
        w_in.imem_ready  = bus.imem_ready;
        w_in.imem_rvalid = bus.imem_rvalid;
        w_in.imem_rdata  = bus.imem_rdata;
        w_in.flush       = bus.flush;
        w_in.flush_pc    = bus.flush_pc;
        w_in.out_ready   = bus.out_ready;
    end

    assign w_inflight  = {1'b0, w_count} + {1'b0, w_outstanding};
    assign w_req       = ~rst & ~w_in.flush & (w_inflight < c_depth);
    assign w_accept    = w_req & w_in.imem_ready;
    assign w_keep      = w_in.imem_rvalid & ~w_in.flush & (r_discard == '0);
    assign w_out_valid = (w_count != '0);
    assign w_pop       = w_out_valid & w_in.out_ready & ~w_in.flush;

    always_comb begin
        w_push_entry.instr = w_in.imem_rdata;
        w_push_entry.pc    = w_pcq_head;
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_type)),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_keep),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_clear (w_in.flush),
        .o_head  (w_head_entry),
        .o_count (w_count)
    );

    // The PC queue holds one entry per in-flight request, stale ones included,
    // so its occupancy is the outstanding-request count.
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_data  (r_pc),
        .i_pop   (w_in.imem_rvalid),
        .i_clear (1'b0),
        .o_head  (w_pcq_head),
        .o_count (w_outstanding)
    );

    // Outstanding already counts pending discards, so a flush marks every
    // in-flight request still to return as stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= word_align(START_ADDR);
            r_discard <= '0;
        end else if (w_in.flush) begin
            r_pc      <= word_align(w_in.flush_pc);
            r_discard <= w_outstanding - c_cnt_w'(w_in.imem_rvalid);
        end else begin
            if (w_accept) r_pc <= r_pc + 32'd4;
            if (w_in.imem_rvalid && (r_discard != '0)) r_discard <= r_discard - c_cnt_w'(1);
        end
    end

    always_comb begin
        w_out.imem_valid = w_req;
        w_out.imem_addr  = r_pc;
        w_out.out_valid  = w_out_valid;
        w_out.out_instr  = w_out_valid ? w_head_entry.instr : c_nop_instr;
        w_out.out_pc     = w_out_valid ? w_head_entry.pc    : 32'h0;
    end

    assign bus.imem_valid = w_out.imem_valid;
    assign bus.imem_addr  = w_out.imem_addr;
    assign bus.out_valid  = w_out.out_valid;
    assign bus.out_instr  = w_out.out_instr;
    assign bus.out_pc     = w_out.out_pc;

    a_rvalid_needs_request : assert property (@(posedge clk) disable iff (rst)
        w_in.imem_rvalid |-> (w_outstanding != '0))
        else $error("fetch_buffer: imem_rvalid with no outstanding request");

    a_credit_bound : assert property (@(posedge clk) disable iff (rst)
        w_inflight <= c_depth)
        else $error("fetch_buffer: count + outstanding exceeds DEPTH");

endmodule

`default_nettype wire

// File: tb/tb_fetch_buffer.sv
// ============================================================================
// Module   : tb_fetch_buffer
// Brief    : Randomised scoreboard bench for fetch_buffer with an epoch-based
//            reference model of the memory and decode queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_buffer;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] START = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;

    fetch_buffer_if bus();

    fetch_buffer #(
        .DEPTH      (DEPTH),
        .START_ADDR (START)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          epoch;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    req_t inflight[$];
    exp_t exp_q[$];

    int          checks = 0;
    int          errors = 0;
    int          epoch = 0;
    int          cyc = 0;
    logic [31:0] model_pc = START;
    bit          pred_req = 1'b0;
    int          dut_accepts = 0;
    logic [31:0] last_acc_addr = 32'h0;
    int          lat_min = 1, lat_max = 1;
    int          ready_pct = 100, oready_pct = 100, flush_pct = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares DUT outputs against the model and pops on handshake.
    always @(negedge clk) begin : mon
        bit exp_valid;
        exp_valid = !rst && !bus.flush && ((exp_q.size() + inflight.size()) < DEPTH);
        pred_req  = exp_valid;
        chk("imem_valid", 32'(bus.imem_valid), 32'(exp_valid));
        if (exp_valid || rst) chk("imem_addr", bus.imem_addr, model_pc);
        chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            chk("out_instr", bus.out_instr, exp_q[0].instr);
            chk("out_pc", bus.out_pc, exp_q[0].pc);
            if (!rst && bus.out_ready && !bus.flush) void'(exp_q.pop_front());
        end else begin
            chk("out_instr_empty", bus.out_instr, NOP);
            chk("out_pc_empty", bus.out_pc, 32'h0);
        end
        if (bus.imem_valid && bus.imem_ready) begin
            dut_accepts++;
            last_acc_addr = bus.imem_addr;
        end
    end

    // Applies the effect of the clock edge just passed to the reference model.
    task automatic edge_step();
        req_t r;
        exp_t e;
        int   d;
        if (!rst) begin
            if (bus.imem_rvalid) begin
                r = inflight.pop_front();
                if (!bus.flush && r.epoch == epoch) begin
                    e.instr = r.data;
                    e.pc    = r.addr;
                    exp_q.push_back(e);
                end
            end
            if (bus.flush) begin
                exp_q.delete();
                epoch++;
                model_pc = bus.flush_pc & 32'hFFFF_FFFC;
            end else if (pred_req && bus.imem_ready) begin
                d = cyc + int'($urandom_range(lat_max, lat_min));
                if (inflight.size() != 0 && inflight[$].due > d) d = inflight[$].due;
                r.addr  = model_pc;
                r.data  = $urandom;
                r.epoch = epoch;
                r.due   = d;
                inflight.push_back(r);
                model_pc = model_pc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic drive_next();
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = $urandom;
        if (inflight.size() != 0 && inflight[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = inflight[0].data;
        end
        bus.imem_ready = ($urandom_range(99, 0) < ready_pct);
        bus.out_ready  = ($urandom_range(99, 0) < oready_pct);
        bus.flush      = ($urandom_range(99, 0) < flush_pct);
        bus.flush_pc   = $urandom;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        edge_step();
        drive_next();
    endtask

    task automatic finish_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    initial begin : watchdog
        #1_000_000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        finish_run();
    end

    initial begin : stim
        int a0;
        int n;
        rst             = 1'b1;
        bus.imem_ready  = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.flush       = 1'b0;
        bus.flush_pc    = 32'h0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset imem_valid", 32'(bus.imem_valid), 32'h0);
        chk("reset imem_addr", bus.imem_addr, START);
        chk("reset out_valid", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        drive_next();

        // Streaming with an always-ready memory and decoder across the PC wrap.
        repeat (20) cycle();

        // Decoder stalled after a redirect: credit allows exactly DEPTH fetches.
        oready_pct = 0;
        cycle();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0200;
        a0 = dut_accepts;
        repeat (12) cycle();
        chk("accepts while stalled", 32'(dut_accepts - a0), 32'(DEPTH));
        bus.out_ready = 1'b1;
        a0 = dut_accepts;
        repeat (4) cycle();
        chk("accepts after single pop", 32'(dut_accepts - a0), 32'h1);

        // Redirect with several long-latency requests in flight.
        oready_pct = 100;
        lat_min = 3;
        lat_max = 3;
        repeat (8) cycle();
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_1002;
        a0 = dut_accepts;
        n  = 0;
        while (dut_accepts == a0 && n < 20) begin
            cycle();
            n++;
        end
        chk("first request after flush", last_acc_addr, 32'h0000_1000);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            cycle();
            n++;
        end
        chk("first out_pc after flush", bus.out_pc, 32'h0000_1000);

        // Redirect coinciding with a response and a decoder pop.
        lat_min = 1;
        lat_max = 1;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(bus.imem_rvalid && exp_q.size() != 0) && n < 30);
        chk("rvalid with queued entry seen", 32'(bus.imem_rvalid && exp_q.size() != 0), 32'h1);
        bus.flush     = 1'b1;
        bus.flush_pc  = 32'h0000_4000;
        bus.out_ready = 1'b1;
        cycle();
        chk("out_valid after flush", 32'(bus.out_valid), 32'h0);

        // Randomised traffic with redirects.
        lat_min = 1;
        lat_max = 4;
        ready_pct = 70;
        oready_pct = 60;
        flush_pct = 8;
        repeat (1500) cycle();

        // Reset in the middle of traffic, with a stale response during reset.
        flush_pct = 0;
        ready_pct = 100;
        oready_pct = 0;
        lat_min = 3;
        lat_max = 3;
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h0000_0800;
        repeat (5) cycle();
        rst             = 1'b1;
        bus.imem_rvalid = 1'b1;
        bus.flush       = 1'b0;
        #1;
        chk("mid reset imem_valid", 32'(bus.imem_valid), 32'h0);
        chk("mid reset imem_addr", bus.imem_addr, START);
        chk("mid reset out_valid", 32'(bus.out_valid), 32'h0);
        chk("mid reset out_instr", bus.out_instr, NOP);
        chk("mid reset out_pc", bus.out_pc, 32'h0);
        exp_q.delete();
        inflight.delete();
        model_pc = START;
        epoch++;
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        oready_pct = 100;
        lat_min = 1;
        lat_max = 2;
        drive_next();
        a0 = dut_accepts;
        n  = 0;
        while (dut_accepts == a0 && n < 20) begin
            cycle();
            n++;
        end
        chk("first request after reset", last_acc_addr, START);
        repeat (30) cycle();

        finish_run();
    end

endmodule

`default_nettype wire
